fir_coef_sequencer: RTL and testbench
=====================================

Name: fir_coef_sequencer

Overview:
- Controller in front of the 7-tap FIR filter. Stores NUM_PROFILES coefficient sets of 7×8-bit each in a local bank.
- On a profile-select request it stalls the sample stream and waits for the filter's 4-stage pipeline to flush. It then streams the 7 weights over the filter's weight handshake and resumes sample pass-through.

Parameters:
- NUM_PROFILES, 4, number of stored coefficient sets (≥2).
- PW, $clog2(NUM_PROFILES), profile index width.
- FLUSH_CYCLES, 4, idle cycles before reload (mult + 3 adder stages).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_wr_en  in  1  write one bank coefficient this cycle
- cfg_profile  in  PW  bank profile to write
- cfg_idx  in  3  tap index 0..6; value 7 is ignored
- cfg_data  in  8  coefficient value
- sel_valid  in  1  request to switch to a profile
- sel_profile  in  PW  requested profile
- sel_ready  out  1  high only in RUN
- sel_err  out  1  1-cycle pulse when sel_profile ≥ NUM_PROFILES
- in_valid  in  1  upstream sample valid
- in_data  in  8  upstream sample
- in_ready  out  1  upstream ready
- fir_input_valid  out  1  to filter
- fir_input_data  out  8  to filter
- fir_input_ready  in  1  from filter
- fir_weight_valid  out  1  to filter
- fir_weight_idx  out  3  to filter
- fir_weight_data  out  8  to filter
- fir_weight_ready  in  1  from filter
- busy  out  1  high in DRAIN or LOAD
- active_profile  out  PW  profile currently loaded in filter

Behaviour:
- Reset:
  - State = RUN; active_profile = 0; all bank entries = 0 (this matches the filter's zeroed weights after the shared reset).
  - Flush counter = 0; tap counter = 0; all fir_weight_* = 0.
  - sel_err = 0; busy = 0.
- Reset mid-DRAIN or mid-LOAD aborts immediately with the same values as above. No partial weight beat survives reset.
- Bank writes:
  - When cfg_wr_en=1 and cfg_idx≤6 and cfg_profile<NUM_PROFILES, bank[cfg_profile][cfg_idx] <= cfg_data. This applies in any state.
  - A write never changes the filter directly. Writing the active profile takes effect only on the next select.
- RUN state:
  - Combinational pass-through: fir_input_valid=in_valid, fir_input_data=in_data, in_ready=fir_input_ready.
  - sel_ready=1.
  - When sel_valid is high with a valid profile: latch pend_profile, clear the flush counter, go to DRAIN.
  - Re-selecting the current profile still reloads.
  - When sel_valid is high with an invalid profile: sel_err=1 next cycle, state stays RUN, handshake is consumed.
- DRAIN state:
  - in_ready=0 and fir_input_valid=0.
  - Counter increments each cycle. When count==FLUSH_CYCLES-1, clear the tap counter and go to LOAD. DRAIN lasts exactly FLUSH_CYCLES cycles.
- LOAD state:
  - in_ready=0 and fir_input_valid=0.
  - Weight outputs: fir_weight_valid=1, fir_weight_idx=tap, fir_weight_data=bank[pend_profile][tap], read at current cycle.
  - A cfg write landing before its tap's beat is used.
  - On fir_weight_valid & fir_weight_ready: tap++. On the beat with tap==6: active_profile <= pend_profile and next state = RUN.
  - While fir_weight_ready=0 (filter in reset), outputs hold and tap does not advance.
  - Minimum LOAD duration is 7 cycles.
- Total switch latency from sel accept to first RUN cycle is 1+FLUSH_CYCLES+7 = 12 cycles minimum.
- busy = (state≠RUN), driven from registers.
- sel_valid while busy: sel_ready=0, request not taken. The requester holds it per valid/ready rules.
- cfg_wr_en and sel accept in the same cycle: the write lands first in the bank and is visible to the load.

Decomposition:
- Shared fir_pkg holds: N_TAPS=7, COEF_W=8, SAMPLE_W=8, FIR_PIPE_DEPTH=4, and a state enum {RUN, DRAIN, LOAD}. FLUSH_CYCLES defaults to FIR_PIPE_DEPTH.
- One natural sub-module: fir_coef_bank. It is the NUM_PROFILES×7×8 register file with a synchronous-reset write port and an asynchronous read port.

Test Plan:
- Reset, then in_valid=1 with data 5 → fir_input_valid=1 and data 5 pass through the same cycle; busy=0; active_profile=0.
- Write profile1 taps = 1..7, then select 1 → 4 cycles with in_ready=0 and no weight beats, then 7 beats with idx 0..6 and data 1..7; active_profile=1 and RUN on cycle 12.
- During LOAD, drop fir_weight_ready for 3 cycles at tap 2 → idx=2 and data=3 held, total load 10 cycles, no beat skipped or duplicated.
- Select profile 5 with NUM_PROFILES=4 → sel_err pulses once, no DRAIN, active_profile unchanged.
- Assert rst at LOAD tap 4 → next cycle state RUN, fir_weight_valid=0, active_profile=0, bank zeroed.
- During DRAIN, write profile1 tap0=0xAA → first LOAD beat carries idx 0 and data 0xAA. Assert sel_valid while busy → sel_ready=0, and the request is accepted only after return to RUN.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and the sequencer state type for the 7-tap FIR filter subsystem.
package fir_pkg;

   localparam int unsigned N_TAPS         = 7;
   localparam int unsigned COEF_W         = 8;
   localparam int unsigned SAMPLE_W       = 8;
   localparam int unsigned FIR_PIPE_DEPTH = 4;
   localparam int unsigned TAP_W          = 3;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      LOAD
   } state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: NUM_PROFILES x N_TAPS entries, synchronous write, asynchronous read.
// Writes to a nonexistent profile or to tap index 7 match no entry and are dropped.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int unsigned NUM_PROFILES = 4,
   parameter int unsigned PW           = $clog2(NUM_PROFILES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [PW-1:0]     i_wr_profile,
   input  logic [TAP_W-1:0]  i_wr_idx,
   input  logic [COEF_W-1:0] i_wr_data,
   input  logic [PW-1:0]     i_rd_profile,
   input  logic [TAP_W-1:0]  i_rd_idx,
   output logic [COEF_W-1:0] o_rd_data
);

   logic [COEF_W-1:0] r_mem [NUM_PROFILES][N_TAPS];

   // Storage: cleared on reset so it matches the filter's zeroed weights.
   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < NUM_PROFILES; p++) begin
         for (int unsigned t = 0; t < N_TAPS; t++) begin
            if (rst) begin
               r_mem[p][t] <= '0;
            end else if (i_wr_en && (i_wr_profile == PW'(p)) && (i_wr_idx == TAP_W'(t))) begin
               r_mem[p][t] <= i_wr_data;
            end
         end
      end
   end

   // Read mux: decoded compare avoids indexing past the populated profiles.
   always_comb begin
      o_rd_data = '0;
      for (int unsigned p = 0; p < NUM_PROFILES; p++) begin
         for (int unsigned t = 0; t < N_TAPS; t++) begin
            if ((i_rd_profile == PW'(p)) && (i_rd_idx == TAP_W'(t))) begin
               o_rd_data = r_mem[p][t];
            end
         end
      end
   end

endmodule

// File: rtl/fir_coef_sequencer.sv
// Coefficient sequencer in front of the FIR filter: on a profile select it stalls samples,
// waits for the filter pipeline to flush, streams the 7 weights, then resumes pass-through.
module fir_coef_sequencer
   import fir_pkg::*;
#(
   parameter int unsigned NUM_PROFILES = 4,
   parameter int unsigned PW           = $clog2(NUM_PROFILES),
   parameter int unsigned FLUSH_CYCLES = FIR_PIPE_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_wr_en,
   input  logic [PW-1:0]       cfg_profile,
   input  logic [TAP_W-1:0]    cfg_idx,
   input  logic [COEF_W-1:0]   cfg_data,
   input  logic                sel_valid,
   input  logic [PW-1:0]       sel_profile,
   output logic                sel_ready,
   output logic                sel_err,
   input  logic                in_valid,
   input  logic [SAMPLE_W-1:0] in_data,
   output logic                in_ready,
   output logic                fir_input_valid,
   output logic [SAMPLE_W-1:0] fir_input_data,
   input  logic                fir_input_ready,
   output logic                fir_weight_valid,
   output logic [TAP_W-1:0]    fir_weight_idx,
   output logic [COEF_W-1:0]   fir_weight_data,
   input  logic                fir_weight_ready,
   output logic                busy,
   output logic [PW-1:0]       active_profile
);

   localparam int unsigned      CW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0]    FlushLast = CW'(FLUSH_CYCLES - 1);
   localparam logic [TAP_W-1:0] LastTap   = TAP_W'(N_TAPS - 1);

   state_e            r_state,          w_state_next;
   logic [CW-1:0]     r_flush_cnt,      w_flush_cnt_next;
   logic [TAP_W-1:0]  r_tap,            w_tap_next;
   logic [PW-1:0]     r_pend_profile,   w_pend_profile_next;
   logic [PW-1:0]     r_active_profile, w_active_profile_next;
   logic              r_sel_err,        w_sel_err_next;
   logic              w_sel_ok;
   logic [COEF_W-1:0] w_bank_data;

   fir_coef_bank #(
      .NUM_PROFILES (NUM_PROFILES),
      .PW           (PW)
   ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .i_wr_en      (cfg_wr_en),
      .i_wr_profile (cfg_profile),
      .i_wr_idx     (cfg_idx),
      .i_wr_data    (cfg_data),
      .i_rd_profile (r_pend_profile),
      .i_rd_idx     (r_tap),
      .o_rd_data    (w_bank_data)
   );

   // Select range check: decoded so non-power-of-two profile counts need no compare tricks.
   always_comb begin
      w_sel_ok = 1'b0;
      for (int unsigned p = 0; p < NUM_PROFILES; p++) begin
         if (sel_profile == PW'(p)) begin
            w_sel_ok = 1'b1;
         end
      end
   end

   // State and datapath registers; reset aborts any drain or load in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= RUN;
         r_flush_cnt      <= '0;
         r_tap            <= '0;
         r_pend_profile   <= '0;
         r_active_profile <= '0;
         r_sel_err        <= 1'b0;
      end else begin
         r_state          <= w_state_next;
         r_flush_cnt      <= w_flush_cnt_next;
         r_tap            <= w_tap_next;
         r_pend_profile   <= w_pend_profile_next;
         r_active_profile <= w_active_profile_next;
         r_sel_err        <= w_sel_err_next;
      end
   end

   // Next-state logic and handshake outputs for RUN / DRAIN / LOAD.
   always_comb begin
      w_state_next          = r_state;
      w_flush_cnt_next      = r_flush_cnt;
      w_tap_next            = r_tap;
      w_pend_profile_next   = r_pend_profile;
      w_active_profile_next = r_active_profile;
      w_sel_err_next        = 1'b0;
      sel_ready             = 1'b0;
      in_ready              = 1'b0;
      fir_input_valid       = 1'b0;
      fir_input_data        = in_data;
      fir_weight_valid      = 1'b0;
      fir_weight_idx        = '0;
      fir_weight_data       = '0;

      unique case (r_state)
         RUN: begin
            sel_ready       = 1'b1;
            in_ready        = fir_input_ready;
            fir_input_valid = in_valid;
            if (sel_valid) begin
               if (w_sel_ok) begin
                  w_pend_profile_next = sel_profile;
                  w_flush_cnt_next    = '0;
                  w_state_next        = DRAIN;
               end else begin
                  // Invalid request is consumed and only flagged.
                  w_sel_err_next = 1'b1;
               end
            end
         end
         DRAIN: begin
            w_flush_cnt_next = r_flush_cnt + CW'(1);
            if (r_flush_cnt == FlushLast) begin
               w_tap_next   = '0;
               w_state_next = LOAD;
            end
         end
         LOAD: begin
            fir_weight_valid = 1'b1;
            fir_weight_idx   = r_tap;
            fir_weight_data  = w_bank_data;
            if (fir_weight_ready) begin
               if (r_tap == LastTap) begin
                  w_active_profile_next = r_pend_profile;
                  w_state_next          = RUN;
               end else begin
                  w_tap_next = r_tap + TAP_W'(1);
               end
            end
         end
         default: begin
            w_state_next = RUN;
         end
      endcase
   end

   assign busy           = (r_state != RUN);
   assign sel_err        = r_sel_err;
   assign active_profile = r_active_profile;

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Scoreboard bench for fir_coef_sequencer: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of profile switches.
module tb_fir_coef_sequencer;
   import fir_pkg::*;

   localparam int unsigned NP = 5;
   localparam int unsigned PW = $clog2(NP);
   localparam int unsigned FC = FIR_PIPE_DEPTH;

   logic                clk;
   logic                rst;
   logic                cfg_wr_en;
   logic [PW-1:0]       cfg_profile;
   logic [TAP_W-1:0]    cfg_idx;
   logic [COEF_W-1:0]   cfg_data;
   logic                sel_valid;
   logic [PW-1:0]       sel_profile;
   logic                sel_ready;
   logic                sel_err;
   logic                in_valid;
   logic [SAMPLE_W-1:0] in_data;
   logic                in_ready;
   logic                fir_input_valid;
   logic [SAMPLE_W-1:0] fir_input_data;
   logic                fir_input_ready;
   logic                fir_weight_valid;
   logic [TAP_W-1:0]    fir_weight_idx;
   logic [COEF_W-1:0]   fir_weight_data;
   logic                fir_weight_ready;
   logic                busy;
   logic [PW-1:0]       active_profile;

   fir_coef_sequencer #(
      .NUM_PROFILES (NP),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_wr_en        (cfg_wr_en),
      .cfg_profile      (cfg_profile),
      .cfg_idx          (cfg_idx),
      .cfg_data         (cfg_data),
      .sel_valid        (sel_valid),
      .sel_profile      (sel_profile),
      .sel_ready        (sel_ready),
      .sel_err          (sel_err),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_ready         (in_ready),
      .fir_input_valid  (fir_input_valid),
      .fir_input_data   (fir_input_data),
      .fir_input_ready  (fir_input_ready),
      .fir_weight_valid (fir_weight_valid),
      .fir_weight_idx   (fir_weight_idx),
      .fir_weight_data  (fir_weight_data),
      .fir_weight_ready (fir_weight_ready),
      .busy             (busy),
      .active_profile   (active_profile)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: bank contents, pending weight beats, and switch progress.
   typedef struct {
      int unsigned prof;
      int unsigned idx;
   } beat_t;

   beat_t       exp_q[$];
   int unsigned m_bank [NP][N_TAPS];
   bit          m_busy;
   bit          m_err;
   int unsigned m_active;
   int unsigned m_drain;
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s at cycle %0d: got no event within bound, expected one", name, cyc);
   endtask

   task automatic model_reset();
      foreach (m_bank[p, t]) m_bank[p][t] = 0;
      exp_q.delete();
      m_busy   = 1'b0;
      m_err    = 1'b0;
      m_active = 0;
      m_drain  = 0;
   endtask

   task automatic monitor_step();
      bit    sel_ok;
      bit    accept;
      bit    beat;
      bit    err_n;
      beat_t b;
      check("busy", 32'(busy), 32'(m_busy));
      check("sel_ready", 32'(sel_ready), 32'(!m_busy));
      check("active_profile", 32'(active_profile), m_active);
      check("sel_err", 32'(sel_err), 32'(m_err));
      if (!m_busy) begin
         check("pass_valid", 32'(fir_input_valid), 32'(in_valid));
         check("pass_data", 32'(fir_input_data), 32'(in_data));
         check("pass_ready", 32'(in_ready), 32'(fir_input_ready));
         check("idle_weight_valid", 32'(fir_weight_valid), 32'd0);
      end else begin
         check("stall_valid", 32'(fir_input_valid), 32'd0);
         check("stall_ready", 32'(in_ready), 32'd0);
         if (m_drain > 0) begin
            check("drain_weight_valid", 32'(fir_weight_valid), 32'd0);
         end else if (exp_q.size() == 0) begin
            fail_bound("beat_queue_empty");
         end else begin
            b = exp_q[0];
            check("load_weight_valid", 32'(fir_weight_valid), 32'd1);
            check("weight_idx", 32'(fir_weight_idx), b.idx);
            check("weight_data", 32'(fir_weight_data), m_bank[b.prof][b.idx]);
         end
      end
      // Effects of the coming clock edge.
      sel_ok = (sel_profile < NP);
      accept = !m_busy && sel_valid && sel_ok;
      err_n  = !m_busy && sel_valid && !sel_ok;
      beat   = m_busy && (m_drain == 0) && fir_weight_ready && (exp_q.size() > 0);
      if (beat) begin
         b = exp_q.pop_front();
         if (exp_q.size() == 0) begin
            m_busy   = 1'b0;
            m_active = b.prof;
         end
      end else if (m_busy && (m_drain > 0)) begin
         m_drain--;
      end
      if (accept) begin
         m_busy  = 1'b1;
         m_drain = FC;
         for (int unsigned i = 0; i < N_TAPS; i++) exp_q.push_back('{32'(sel_profile), i});
      end
      if (cfg_wr_en && (cfg_idx <= 6) && (cfg_profile < NP)) begin
         m_bank[cfg_profile][cfg_idx] = 32'(cfg_data);
      end
      m_err = err_n;
   endtask

   always @(negedge clk) begin
      if (rst) model_reset();
      else monitor_step();
   end

   task automatic cfg_write(input int unsigned p, input int unsigned t, input int unsigned d);
      cfg_wr_en   = 1'b1;
      cfg_profile = PW'(p);
      cfg_idx     = TAP_W'(t);
      cfg_data    = COEF_W'(d);
      @(posedge clk); #1;
      cfg_wr_en = 1'b0;
   endtask

   task automatic do_select(input int unsigned p, output int t_acc);
      int n = 0;
      sel_valid   = 1'b1;
      sel_profile = PW'(p);
      @(negedge clk);
      while (!sel_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      t_acc = cyc;
      if (!sel_ready) fail_bound("sel_accept_timeout");
      @(posedge clk); #1;
      sel_valid = 1'b0;
   endtask

   task automatic wait_idle(output int t_idle);
      int n = 0;
      @(negedge clk);
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      t_idle = cyc;
      if (busy) fail_bound("idle_timeout");
      @(posedge clk); #1;
   endtask

   task automatic wait_weight(input int unsigned idx);
      int n = 0;
      @(negedge clk);
      while (!(fir_weight_valid && (fir_weight_idx == TAP_W'(idx))) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!(fir_weight_valid && (fir_weight_idx == TAP_W'(idx)))) fail_bound("weight_wait_timeout");
   endtask

   initial begin
      int t_acc;
      int t_idle;
      int t_tmp;
      bit acc;
      rst              = 1'b1;
      cfg_wr_en        = 1'b0;
      cfg_profile      = '0;
      cfg_idx          = '0;
      cfg_data         = '0;
      sel_valid        = 1'b0;
      sel_profile      = '0;
      in_valid         = 1'b0;
      in_data          = '0;
      fir_input_ready  = 1'b1;
      fir_weight_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Pass-through right after reset.
      in_valid = 1'b1;
      in_data  = 8'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;

      // Profile 1 = 1..7, full switch with no back-pressure.
      for (int unsigned t = 0; t < N_TAPS; t++) cfg_write(1, t, t + 1);
      do_select(1, t_acc);
      wait_idle(t_idle);
      check("switch_latency", 32'(t_idle - t_acc), 32'(1 + FC + N_TAPS));

      // Weight back-pressure for 3 cycles at tap 2.
      for (int unsigned t = 0; t < N_TAPS; t++) cfg_write(2, t, 8'h10 + t);
      do_select(2, t_acc);
      wait_weight(1);
      @(posedge clk); #1;
      fir_weight_ready = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      fir_weight_ready = 1'b1;
      wait_idle(t_idle);
      check("stalled_latency", 32'(t_idle - t_acc), 32'(1 + FC + N_TAPS + 3));

      // Out-of-range select: error pulse only.
      do_select(5, t_acc);
      repeat (3) @(posedge clk);
      #1;

      // Reset in the middle of LOAD, then reload from the cleared bank.
      do_select(1, t_acc);
      wait_weight(3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      do_select(1, t_acc);
      wait_idle(t_idle);
      check("post_reset_latency", 32'(t_idle - t_acc), 32'(1 + FC + N_TAPS));

      // Write during DRAIN lands in the load; a second select waits while busy.
      do_select(1, t_acc);
      cfg_write(1, 0, 8'hAA);
      do_select(3, t_tmp);
      check("held_select_wait", 32'(t_tmp - t_acc), 32'(1 + FC + N_TAPS));
      wait_idle(t_idle);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         acc = sel_valid && sel_ready;
         @(posedge clk); #1;
         cfg_wr_en        = 1'($urandom_range(0, 1));
         cfg_profile      = PW'($urandom_range(0, 7));
         cfg_idx          = TAP_W'($urandom_range(0, 7));
         cfg_data         = COEF_W'($urandom);
         in_valid         = 1'($urandom_range(0, 1));
         in_data          = SAMPLE_W'($urandom);
         fir_input_ready  = 1'($urandom_range(0, 1));
         fir_weight_ready = ($urandom_range(0, 3) != 0);
         if (acc) sel_valid = 1'b0;
         if (!sel_valid && ($urandom_range(0, 15) == 0)) begin
            sel_valid   = 1'b1;
            sel_profile = PW'($urandom_range(0, 7));
         end
      end
      sel_valid        = 1'b0;
      cfg_wr_en        = 1'b0;
      fir_weight_ready = 1'b1;
      wait_idle(t_idle);
      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
